// File: rtl/mdu_iter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mdu_iter_pkg : opcodes, FSM states and op decode helpers for the MDU
// rev 1.0
// ----------------------------------------------------------------------------
package mdu_iter_pkg;

  localparam logic [7:0] AND_OP   = 8'b0010_0100;
  localparam logic [7:0] MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] DIVU_OP  = 8'b0001_1011;
  localparam logic [7:0] MADD_OP  = 8'b1010_0110;
  localparam logic [7:0] MADDU_OP = 8'b1010_1000;
  localparam logic [7:0] MSUB_OP  = 8'b1010_1010;
  localparam logic [7:0] MSUBU_OP = 8'b1010_1011;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } mdu_state_t;

  typedef enum logic [1:0] {
    K_MUL  = 2'd0,
    K_MADD = 2'd1,
    K_MSUB = 2'd2,
    K_DIV  = 2'd3
  } mdu_kind_t;

  function automatic logic op_supported(input logic [7:0] op);
    case (op)
      MULT_OP, MULTU_OP, DIV_OP, DIVU_OP,
      MADD_OP, MADDU_OP, MSUB_OP, MSUBU_OP: op_supported = 1'b1;
      default:                              op_supported = 1'b0;
    endcase
  endfunction

  function automatic logic op_signed(input logic [7:0] op);
    case (op)
      MULT_OP, DIV_OP, MADD_OP, MSUB_OP: op_signed = 1'b1;
      default:                           op_signed = 1'b0;
    endcase
  endfunction

  function automatic mdu_kind_t op_kind(input logic [7:0] op);
    case (op)
      DIV_OP, DIVU_OP:   op_kind = K_DIV;
      MADD_OP, MADDU_OP: op_kind = K_MADD;
      MSUB_OP, MSUBU_OP: op_kind = K_MSUB;
      default:           op_kind = K_MUL;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_div_step.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mdu_div_step : STEPS combinational restoring-division iterations on {rem,quot}
// rev 1.0
// ----------------------------------------------------------------------------
module mdu_div_step #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH-1:0] rem_c  [0:STEPS];
  logic [WIDTH-1:0] quot_c [0:STEPS];

  assign rem_c[0]  = rem_i;
  assign quot_c[0] = quot_i;

  for (genvar i = 0; i < STEPS; i++) begin : g_iter
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;
    logic           fits;

    // Dividend bits shift in from the quotient register MSB-first.
    assign trial = {rem_c[i], quot_c[i][WIDTH-1]};
    assign diff  = trial - {1'b0, divisor_i};
    assign fits  = (trial >= {1'b0, divisor_i});
    assign rem_c[i+1]  = fits ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quot_c[i+1] = {quot_c[i][WIDTH-2:0], fits};
  end : g_iter

  assign rem_o  = rem_c[STEPS];
  assign quot_o = quot_c[STEPS];

endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mdu_iter : iterative MULT/DIV/MADD/MSUB unit producing the {HI,LO} pair
// rev 1.0
// ----------------------------------------------------------------------------
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int MUL_STEP = 2,
  parameter int DIV_STEP = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [7:0]           aluop_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic [2*WIDTH-1:0]   hilo_rdata_i,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 hilo_we_o,
  output logic [2*WIDTH-1:0]   hilo_wdata_o
);

  localparam int             CW    = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  MUL_N = CW'(WIDTH / MUL_STEP);
  localparam logic [CW-1:0]  DIV_N = CW'(WIDTH / DIV_STEP);

  mdu_state_t          state;
  mdu_kind_t           kind;
  logic [CW-1:0]       cnt;
  logic                neg_lo;
  logic                neg_hi;
  logic [2*WIDTH-1:0]  mcand;
  logic [WIDTH-1:0]    opb;
  logic [2*WIDTH-1:0]  acc;
  logic [WIDTH-1:0]    rem;
  logic [WIDTH-1:0]    quot;
  logic [2*WIDTH-1:0]  hilo_cap;

  logic                accept;
  logic                sgn;
  logic                neg1;
  logic                neg2;
  logic [WIDTH-1:0]    abs1;
  logic [WIDTH-1:0]    abs2;
  logic [2*WIDTH-1:0]  mul_add;
  logic [WIDTH-1:0]    rem_nx;
  logic [WIDTH-1:0]    quot_nx;
  logic [2*WIDTH-1:0]  prod_s;
  logic [2*WIDTH-1:0]  fix_result;

  assign accept = (state == S_IDLE) && start_i && op_supported(aluop_i) && !flush_i;
  assign sgn    = op_signed(aluop_i);
  assign neg1   = sgn & opdata1_i[WIDTH-1];
  assign neg2   = sgn & opdata2_i[WIDTH-1];
  assign abs1   = neg1 ? -opdata1_i : opdata1_i;
  assign abs2   = neg2 ? -opdata2_i : opdata2_i;

  always_comb begin
    mul_add = '0;
    for (int k = 0; k < MUL_STEP; k++) begin
      if (opb[k]) mul_add = mul_add + (mcand << k);
    end
  end

  mdu_div_step #(
    .WIDTH (WIDTH),
    .STEPS (DIV_STEP)
  ) u_div_step (
    .rem_i     (rem),
    .quot_i    (quot),
    .divisor_i (opb),
    .rem_o     (rem_nx),
    .quot_o    (quot_nx)
  );

  always_comb begin
    prod_s = neg_lo ? -acc : acc;
    case (kind)
      K_MADD:  fix_result = hilo_cap + prod_s;
      K_MSUB:  fix_result = hilo_cap - prod_s;
      K_DIV:   fix_result = {(neg_hi ? -rem : rem), (neg_lo ? -quot : quot)};
      default: fix_result = prod_s;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      kind         <= K_MUL;
      cnt          <= '0;
      neg_lo       <= 1'b0;
      neg_hi       <= 1'b0;
      mcand        <= '0;
      opb          <= '0;
      acc          <= '0;
      rem          <= '0;
      quot         <= '0;
      hilo_cap     <= '0;
      hilo_wdata_o <= '0;
    end else if (flush_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            kind     <= op_kind(aluop_i);
            hilo_cap <= hilo_rdata_i;
            mcand    <= {{WIDTH{1'b0}}, abs1};
            opb      <= abs2;
            acc      <= '0;
            rem      <= '0;
            quot     <= abs1;
            neg_hi   <= neg1;
            if (op_kind(aluop_i) == K_DIV) begin
              // A zero divisor keeps the raw all-ones quotient from the array.
              neg_lo <= (neg1 ^ neg2) & (|opdata2_i);
              cnt    <= DIV_N;
              state  <= S_DIV;
            end else begin
              neg_lo <= neg1 ^ neg2;
              cnt    <= MUL_N;
              state  <= S_MUL;
            end
          end
        end
        S_MUL: begin
          acc   <= acc + mul_add;
          mcand <= mcand << MUL_STEP;
          opb   <= opb >> MUL_STEP;
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_FIX;
        end
        S_DIV: begin
          rem  <= rem_nx;
          quot <= quot_nx;
          cnt  <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= S_FIX;
        end
        S_FIX: begin
          hilo_wdata_o <= fix_result;
          state        <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o    = accept || (state == S_MUL) || (state == S_DIV) || (state == S_FIX);
  assign done_o    = (state == S_DONE) && !flush_i;
  assign hilo_we_o = done_o;

endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mdu_iter : directed vector table plus multi-cycle corner sequences
// rev 1.0
// ----------------------------------------------------------------------------
module tb_mdu_iter;
  import mdu_iter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [7:0]  aluop_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] hilo_rdata_i;
  logic        flush_i;
  logic        busy_o;
  logic        done_o;
  logic        hilo_we_o;
  logic [63:0] hilo_wdata_o;

  mdu_iter #(.WIDTH(32), .MUL_STEP(2), .DIV_STEP(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .aluop_i      (aluop_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .hilo_rdata_i (hilo_rdata_i),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .hilo_we_o    (hilo_we_o),
    .hilo_wdata_o (hilo_wdata_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hilo;
    logic [63:0] exp;
    int          n;
    bit          poke;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts at posedge+1 and leaves at posedge+1; hilo_rdata_i is scrambled after accept.
  task automatic do_op(input vec_t v, input string name);
    int          dcyc = -1;
    int          pulses = 0;
    int          busy_err = 0;
    int          we_err = 0;
    logic [63:0] got = '0;
    logic [63:0] last = '0;
    aluop_i = v.op; opdata1_i = v.a; opdata2_i = v.b; hilo_rdata_i = v.hilo; start_i = 1'b1;
    #1 chk({name, " busy@0"}, 64'(busy_o), 64'd1);
    @(posedge clk); #1;
    start_i = 1'b0; opdata1_i = 32'h5A5A_0001; opdata2_i = 32'h3; hilo_rdata_i = 64'h0123_4567_89AB_CDEF;
    for (int cyc = 1; cyc <= v.n + 4; cyc++) begin
      if (v.poke && cyc == 3) begin start_i = 1'b1; aluop_i = DIVU_OP; end
      if (cyc == 4) start_i = 1'b0;
      #1;
      if (done_o === 1'b1) begin pulses++; dcyc = cyc; got = hilo_wdata_o; end
      if (hilo_we_o !== done_o) we_err++;
      if (busy_o !== (cyc <= v.n + 1)) busy_err++;
      last = hilo_wdata_o;
      @(posedge clk); #1;
    end
    chk({name, " done_cycle"}, 64'(dcyc), 64'(v.n + 2));
    chk({name, " done_pulses"}, 64'(pulses), 64'd1);
    chk({name, " result"}, got, v.exp);
    chk({name, " held"}, last, v.exp);
    chk({name, " busy_errs"}, 64'(busy_err), 64'd0);
    chk({name, " we_errs"}, 64'(we_err), 64'd0);
  endtask

  task automatic count_idle(input string name, input int ncyc);
    int dn = 0;
    int bz = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (done_o !== 1'b0 || hilo_we_o !== 1'b0) dn++;
      if (busy_o !== 1'b0) bz++;
      @(posedge clk); #1;
    end
    chk({name, " no_done"}, 64'(dn), 64'd0);
    chk({name, " no_busy"}, 64'(bz), 64'd0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1; start_i = 1'b0; aluop_i = 8'h00; opdata1_i = '0; opdata2_i = '0;
    hilo_rdata_i = '0; flush_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy_o), 64'd0);
    chk("reset done", 64'(done_o), 64'd0);
    chk("reset we", 64'(hilo_we_o), 64'd0);
    chk("reset wdata", hilo_wdata_o, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    vecs[0]  = '{MULTU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0, 64'hFFFF_FFFE_0000_0001, 16, 1'b0};
    vecs[1]  = '{MULT_OP,  32'hFFFF_FFFD, 32'd5,        64'h0, 64'hFFFF_FFFF_FFFF_FFF1, 16, 1'b0};
    vecs[2]  = '{DIV_OP,   32'hFFFF_FFF9, 32'd2,        64'h0, 64'hFFFF_FFFF_FFFF_FFFD, 32, 1'b0};
    vecs[3]  = '{DIVU_OP,  32'd7,         32'd2,        64'h0, 64'h0000_0001_0000_0003, 32, 1'b0};
    vecs[4]  = '{DIV_OP,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0, 64'h0000_0000_8000_0000, 32, 1'b0};
    vecs[5]  = '{DIVU_OP,  32'h1234,      32'd0,        64'h0, 64'h0000_1234_FFFF_FFFF, 32, 1'b0};
    vecs[6]  = '{MADD_OP,  32'd2,         32'd3,        64'h1, 64'h0000_0000_0000_0007, 16, 1'b0};
    vecs[7]  = '{MSUBU_OP, 32'd1,         32'd1,        64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 16, 1'b0};
    vecs[8]  = '{MULTU_OP, 32'h0001_0000, 32'h0001_0000, 64'h0, 64'h0000_0001_0000_0000, 16, 1'b1};
    vecs[9]  = '{MULT_OP,  32'h8000_0000, 32'h8000_0000, 64'h0, 64'h4000_0000_0000_0000, 16, 1'b0};
    vecs[10] = '{DIV_OP,   32'd7,         32'hFFFF_FFFE, 64'h0, 64'h0000_0001_FFFF_FFFD, 32, 1'b0};
    vecs[11] = '{MSUB_OP,  32'hFFFF_FFFE, 32'd3,        64'h10, 64'h0000_0000_0000_0016, 16, 1'b0};
    vecs[12] = '{MADDU_OP, 32'd1,         32'd1,        64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 16, 1'b0};
    vecs[13] = '{DIVU_OP,  32'd100,       32'd7,        64'h0, 64'h0000_0002_0000_000E, 32, 1'b0};

    for (int i = 0; i < 14; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Flush at cycle 5 of a DIV, then restart on the very next cycle.
    aluop_i = DIV_OP; opdata1_i = 32'd50; opdata2_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    #1 chk("flush busy@5", 64'(busy_o), 64'd1);
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush busy@6", 64'(busy_o), 64'd0);
    chk("flush done@6", 64'(done_o), 64'd0);
    v = '{DIVU_OP, 32'd7, 32'd2, 64'h0, 64'h0000_0001_0000_0003, 32, 1'b0};
    do_op(v, "after_flush");

    // Flush together with start: the request must not be taken.
    aluop_i = DIVU_OP; opdata1_i = 32'd9; opdata2_i = 32'd2; start_i = 1'b1; flush_i = 1'b1;
    #1 chk("flush+start busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    count_idle("flush+start", 36);

    // Flush landing exactly on the DONE cycle suppresses the write.
    aluop_i = MULTU_OP; opdata1_i = 32'd3; opdata2_i = 32'd4; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (17) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    #1;
    chk("flush@done done", 64'(done_o), 64'd0);
    chk("flush@done we", 64'(hilo_we_o), 64'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    count_idle("flush@done", 4);

    // Unsupported opcode is ignored.
    aluop_i = AND_OP; opdata1_i = 32'd3; opdata2_i = 32'd4; start_i = 1'b1;
    #1 chk("and_op busy", 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    start_i = 1'b0;
    count_idle("and_op", 20);

    // Asynchronous reset between clock edges mid-MUL.
    aluop_i = MULTU_OP; opdata1_i = 32'hFFFF_FFFF; opdata2_i = 32'hFFFF_FFFF; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst busy", 64'(busy_o), 64'd0);
    chk("async_rst done", 64'(done_o), 64'd0);
    chk("async_rst we", 64'(hilo_we_o), 64'd0);
    chk("async_rst wdata", hilo_wdata_o, 64'd0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    count_idle("post_rst", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
